// File: rtl/vec_cons_shifter.sv
// vec_cons_shifter: registered vector of DEPTH elements updated by per-beat
// cons/snoc/rotate/clear operations. The vector is offered downstream once it is full.
//
// state | meaning
// FILL  | accepting input beats; the vector is not offered downstream
// HOLD  | vector full; offered on vec_out until the consumer takes it
module vec_cons_shifter #(
  parameter int ELEM_W        = 8,
  parameter int DEPTH         = 16,
  parameter int IN_N          = 2,
  parameter int CNT_W         = 16,
  parameter int FLUSH_ON_READ = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_op,
  input  logic [$clog2(IN_N+1)-1:0]  in_count,
  input  logic [IN_N*ELEM_W-1:0]     in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DEPTH*ELEM_W-1:0]    vec_out,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int DW = CNT_W + 1;

  localparam logic [1:0] OP_CONS  = 2'b00;
  localparam logic [1:0] OP_SNOC  = 2'b01;
  localparam logic [1:0] OP_ROTL  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic {FILL, HOLD} state_e;

  state_e            state;
  logic [ELEM_W-1:0] vec_q   [DEPTH];
  logic [ELEM_W-1:0] vec_nxt [DEPTH];
  logic [ELEM_W-1:0] in_elem [IN_N];
  logic [LW-1:0]     lvl_nxt;
  logic [CNT_W-1:0]  drop_nxt;
  logic [DW-1:0]     drop_sum;
  logic              to_hold;
  int                k;
  int                lvl_sum;
  int                over;

  // Unpack the input beat into elements.
  always_comb begin
    for (int j = 0; j < IN_N; j++) begin
      in_elem[j] = in_data[j*ELEM_W +: ELEM_W];
    end
  end

  // Present the vector with element 0 in the most significant slot.
  always_comb begin
    vec_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vec_out[(DEPTH-i)*ELEM_W-1 -: ELEM_W] = vec_q[i];
    end
  end

  // Next vector, level and drop count for an accepted beat.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vec_nxt[i] = vec_q[i];
    end
    lvl_nxt  = level;
    drop_nxt = drop_cnt;
    to_hold  = 1'b0;
    // oversize counts saturate to the port width
    k        = (int'(in_count) > IN_N) ? IN_N : int'(in_count);
    lvl_sum  = int'(level) + k;
    over     = (lvl_sum > DEPTH) ? (lvl_sum - DEPTH) : 0;
    drop_sum = {1'b0, drop_cnt} + DW'(over);

    case (in_op)
      OP_CONS: begin
        if (k > 0) begin
          for (int i = 0; i < DEPTH; i++) begin
            vec_nxt[i] = (i >= k) ? vec_q[i-k] : '0;
          end
          for (int j = 0; j < IN_N; j++) begin
            if (j < k) vec_nxt[j] = in_elem[j];
          end
        end
      end
      OP_SNOC: begin
        if (k > 0) begin
          for (int i = 0; i < DEPTH; i++) begin
            vec_nxt[i] = (i < DEPTH - k) ? vec_q[i+k] : '0;
          end
          for (int j = 0; j < IN_N; j++) begin
            if (j < k) vec_nxt[DEPTH-k+j] = in_elem[j];
          end
        end
      end
      OP_ROTL: begin
        // k never exceeds DEPTH, so one conditional subtract replaces the modulo
        for (int i = 0; i < DEPTH; i++) begin
          vec_nxt[i] = vec_q[(i + k >= DEPTH) ? (i + k - DEPTH) : (i + k)];
        end
      end
      default: begin
        for (int i = 0; i < DEPTH; i++) begin
          vec_nxt[i] = '0;
        end
        lvl_nxt  = '0;
        drop_nxt = '0;
      end
    endcase

    // level and drop accounting shared by CONS and SNOC
    if ((in_op == OP_CONS || in_op == OP_SNOC) && k > 0) begin
      lvl_nxt  = LW'((lvl_sum > DEPTH) ? DEPTH : lvl_sum);
      drop_nxt = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
      // a beat that also overflows still lands on a full vector
      to_hold  = (lvl_sum >= DEPTH);
    end
  end

  // Control FSM and storage; handshake outputs are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      level     <= '0;
      drop_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        vec_q[i] <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            for (int i = 0; i < DEPTH; i++) begin
              vec_q[i] <= vec_nxt[i];
            end
            level    <= lvl_nxt;
            drop_cnt <= drop_nxt;
            if (to_hold) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= FILL;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            if (FLUSH_ON_READ != 0) begin
              level <= '0;
              for (int i = 0; i < DEPTH; i++) begin
                vec_q[i] <= '0;
              end
            end
          end
        end
        default: begin
          state     <= FILL;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_cons_shifter.sv
// Bench for vec_cons_shifter: one flushing and one retaining instance share clock, reset and beat data.
module tb_vec_cons_shifter;

  localparam logic [1:0] CONS  = 2'b00;
  localparam logic [1:0] SNOC  = 2'b01;
  localparam logic [1:0] ROTL  = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0]       in_valid, in_ready, out_valid, out_ready;
  logic [1:0]       in_op;
  logic [1:0]       in_count;
  logic [15:0]      in_data;
  logic [1:0][31:0] vec_o;
  logic [1:0][2:0]  lvl_o;
  logic [1:0][3:0]  drop_o;

  typedef struct {
    logic [31:0] vec;
    logic [2:0]  lvl;
    logic [3:0]  drop;
    logic        hold;
    int          s;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  m_vec [2][4];
  int          m_lvl [2];
  int          m_drop[2];
  bit          m_hold[2];

  always #5 clk = ~clk;

  vec_cons_shifter #(.ELEM_W(8), .DEPTH(4), .IN_N(2), .CNT_W(4), .FLUSH_ON_READ(1)) dut_f (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_op(in_op),
    .in_count(in_count), .in_data(in_data), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .vec_out(vec_o[0]), .level(lvl_o[0]), .drop_cnt(drop_o[0]));

  vec_cons_shifter #(.ELEM_W(8), .DEPTH(4), .IN_N(2), .CNT_W(4), .FLUSH_ON_READ(0)) dut_r (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_op(in_op),
    .in_count(in_count), .in_data(in_data), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .vec_out(vec_o[1]), .level(lvl_o[1]), .drop_cnt(drop_o[1]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int s);
    return {m_vec[s][0], m_vec[s][1], m_vec[s][2], m_vec[s][3]};
  endfunction

  task automatic model_reset(input int s);
    for (int i = 0; i < 4; i++) m_vec[s][i] = 8'h00;
    m_lvl[s] = 0; m_drop[s] = 0; m_hold[s] = 0;
  endtask

  task automatic push_exp(input int s);
    exp_t e;
    e.vec = pack(s); e.lvl = 3'(m_lvl[s]); e.drop = 4'(m_drop[s]); e.hold = m_hold[s]; e.s = s;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("vec%0d", e.s), vec_o[e.s], e.vec);
    chk($sformatf("lvl%0d", e.s), lvl_o[e.s], e.lvl);
    chk($sformatf("drop%0d", e.s), drop_o[e.s], e.drop);
    chk($sformatf("ovld%0d", e.s), out_valid[e.s], e.hold);
    chk($sformatf("irdy%0d", e.s), in_ready[e.s], !e.hold);
  endtask

  task automatic model_beat(input int s, input logic [1:0] op, input int cnt, input logic [15:0] data);
    logic [7:0] old[4];
    int k, sum;
    k = (cnt > 2) ? 2 : cnt;
    for (int i = 0; i < 4; i++) old[i] = m_vec[s][i];
    case (op)
      CONS: if (k > 0) for (int i = 0; i < 4; i++) m_vec[s][i] = (i < k) ? data[i*8 +: 8] : old[i-k];
      SNOC: if (k > 0) for (int i = 0; i < 4; i++) m_vec[s][i] = (i < 4-k) ? old[i+k] : data[(i-4+k)*8 +: 8];
      ROTL: for (int i = 0; i < 4; i++) m_vec[s][i] = old[(i+k) % 4];
      default: model_reset(s);
    endcase
    if ((op == CONS || op == SNOC) && k > 0) begin
      sum = m_lvl[s] + k;
      if (sum > 4) m_drop[s] = (m_drop[s] + sum - 4 > 15) ? 15 : m_drop[s] + sum - 4;
      m_lvl[s]  = (sum > 4) ? 4 : sum;
      m_hold[s] = (m_lvl[s] == 4);
    end
  endtask

  task automatic beat(input int s, input logic [1:0] op, input int cnt, input logic [15:0] data);
    int t = 0;
    @(negedge clk);
    while (!in_ready[s] && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready[s]) begin
      chk($sformatf("in_ready_timeout%0d", s), 0, 1);
      return;
    end
    in_op = op; in_count = 2'(cnt); in_data = data; in_valid[s] = 1'b1;
    @(posedge clk);
    model_beat(s, op, cnt, data);
    push_exp(s);
    #1 in_valid[s] = 1'b0;
    check_out();
  endtask

  task automatic read(input int s);
    int t = 0;
    @(negedge clk);
    while (!out_valid[s] && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid[s]) begin
      chk($sformatf("out_valid_timeout%0d", s), 0, 1);
      return;
    end
    out_ready[s] = 1'b1;
    @(posedge clk);
    m_hold[s] = 0;
    if (s == 0) begin
      for (int i = 0; i < 4; i++) m_vec[s][i] = 8'h00;
      m_lvl[s] = 0;
    end
    push_exp(s);
    #1 out_ready[s] = 1'b0;
    check_out();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = '0; out_ready = '0; in_op = CONS; in_count = '0; in_data = '0;
    model_reset(0); model_reset(1);

    #12;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_vec%0d", s), vec_o[s], 0);
      chk($sformatf("rst_lvl%0d", s), lvl_o[s], 0);
      chk($sformatf("rst_drop%0d", s), drop_o[s], 0);
      chk($sformatf("rst_ovld%0d", s), out_valid[s], 0);
      chk($sformatf("rst_irdy%0d", s), in_ready[s], 0);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("irdy_after_rel0", in_ready[0], 1);
    chk("irdy_after_rel1", in_ready[1], 1);

    // two CONS beats fill the flushing instance
    beat(0, CONS, 2, 16'hBBAA);
    beat(0, CONS, 2, 16'hDDCC);
    chk("t1_vec", vec_o[0], 32'hCCDDAABB);
    chk("t1_ovld", out_valid[0], 1);

    // flush on read
    read(0);
    chk("t2_vec", vec_o[0], 32'h0);
    chk("t2_irdy", in_ready[0], 1);

    // retaining instance: full, read, then SNOC one more
    beat(1, SNOC, 2, 16'h2211);
    beat(1, SNOC, 2, 16'h4433);
    chk("t3_full", vec_o[1], 32'h11223344);
    read(1);
    chk("t3_kept_lvl", lvl_o[1], 4);
    beat(1, SNOC, 1, 16'h0055);
    chk("t3_vec", vec_o[1], 32'h22334455);
    chk("t3_drop", drop_o[1], 1);
    chk("t3_ovld", out_valid[1], 1);

    // rotate on a partial vector, including a saturated count, and a k=0 no-op
    beat(0, SNOC, 2, 16'h2211);
    beat(0, SNOC, 1, 16'h0033);
    beat(0, ROTL, 1, 16'hFFFF);
    chk("t4_rot1", vec_o[0], 32'h11223300);
    beat(0, ROTL, 3, 16'hFFFF);
    chk("t4_rot2", vec_o[0], 32'h33001122);
    chk("t4_lvl", lvl_o[0], 3);
    beat(0, CONS, 0, 16'hFFFF);
    chk("t4_noop", vec_o[0], 32'h33001122);
    // an overflowing beat still enters HOLD
    beat(0, CONS, 2, 16'h6655);
    chk("t4_ovf_drop", drop_o[0], 1);
    chk("t4_ovf_hold", out_valid[0], 1);

    // drop counter saturation and CLEAR on the retaining instance
    read(1);
    for (int b = 0; b < 9; b++) begin
      beat(1, CONS, 2, 16'($urandom_range(0, 65535)));
      read(1);
    end
    chk("t5_sat", drop_o[1], 15);
    beat(1, CLEAR, 2, 16'hABCD);
    chk("t5_clr_drop", drop_o[1], 0);
    chk("t5_clr_lvl", lvl_o[1], 0);

    // async reset mid-HOLD with out_ready high
    @(negedge clk);
    chk("t6_pre_hold", out_valid[0], 1);
    out_ready[0] = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("t6_ovld", out_valid[0], 0);
    chk("t6_lvl", lvl_o[0], 0);
    chk("t6_vec", vec_o[0], 0);
    chk("t6_drop", drop_o[0], 0);
    chk("t6_irdy", in_ready[0], 0);
    out_ready[0] = 1'b0;
    model_reset(0); model_reset(1);
    sb.delete();
    @(negedge clk) rst = 1'b1;
    #1 chk("t6_irdy_rel", in_ready[0], 0);
    @(posedge clk); #1;
    chk("t6_irdy_edge", in_ready[0], 1);
    beat(0, CONS, 1, 16'h0077);
    chk("t6_after", vec_o[0], 32'h77000000);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
